// File: rtl/ecc_mem_ctrl_if.sv
// Request/response bus between a single requester and the ECC memory sequencer.
// The requester side uses the master modport and the sequencer uses the slave modport.
interface ecc_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  // Request channel: valid/ready handshake.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  // Response channel: single-cycle pulse with no backpressure.
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_error
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_error
  );
endinterface

// File: rtl/ecc_mem_ctrl.sv
// Single-port sequencer in front of an ECC-protected memory.
// Arbitrates one bus requester against a background scrubber that walks every word.
// A read that reports a correctable error is repaired by writing the corrected word back.
// Correctable and uncorrectable events are counted in saturating counters.
module ecc_mem_ctrl #(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 8192,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int MAX_DEFER      = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_scrub_en,
  ecc_mem_ctrl_if.slave         bus,
  output logic                  o_mem_clk_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write_en,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  input  logic                  i_mem_error,
  input  logic                  i_mem_uncorrectable,
  output logic [CNT_WIDTH-1:0]  o_corr_count,
  output logic [CNT_WIDTH-1:0]  o_uncorr_count,
  output logic [ADDR_WIDTH-1:0] o_last_err_addr
);

  // Timer needs to count 0..SCRUB_INTERVAL-1; keep at least one bit so a
  // disabled or single-cycle interval still elaborates cleanly.
  localparam int TW  = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int DFW = $clog2(MAX_DEFER + 1);

  localparam logic [TW-1:0]         TIMER_LAST = TW'((SCRUB_INTERVAL > 0) ? SCRUB_INTERVAL - 1 : 0);
  localparam logic [DFW-1:0]        DEFER_MAX  = DFW'(MAX_DEFER);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WRBACK  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  // In-flight access bookkeeping.
  logic                  r_src_scrub;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wb_data;

  // Registered response.
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_error;

  // Error statistics.
  logic [CNT_WIDTH-1:0]  r_corr_cnt;
  logic [CNT_WIDTH-1:0]  r_uncorr_cnt;
  logic [ADDR_WIDTH-1:0] r_last_err_addr;

  // Scrubber state.
  logic [ADDR_WIDTH-1:0] r_scrub_ptr;
  logic [TW-1:0]         r_timer;
  logic                  r_scrub_pending;
  logic [DFW-1:0]        r_defer_cnt;

  // Combinational decode.
  logic                  w_pending_eff;
  logic                  w_timer_run;
  logic                  w_timer_expire;
  logic                  w_force;
  logic                  w_req_ready;
  logic                  w_bus_accept;
  logic                  w_bus_read;
  logic                  w_bus_write;
  logic                  w_scrub_issue;
  logic                  w_rd_corr;
  logic                  w_rd_uncorr;
  logic                  w_mem_clk_en;
  logic                  w_mem_write_en;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_write_data;

  // A pending scrub only counts while scrubbing is enabled; disabling drops it.
  assign w_pending_eff  = r_scrub_pending && i_scrub_en;
  assign w_timer_run    = (SCRUB_INTERVAL != 0) && i_scrub_en;
  assign w_timer_expire = w_timer_run && (r_timer == TIMER_LAST);

  // Read-return classification, only meaningful while waiting on a read.
  assign w_rd_uncorr = (r_state == ST_RD_WAIT) && i_mem_uncorrectable;
  assign w_rd_corr   = (r_state == ST_RD_WAIT) && i_mem_error && !i_mem_uncorrectable;

  assign w_bus_read  = w_bus_accept && !bus.req_write;
  assign w_bus_write = w_bus_accept && bus.req_write;

  // Arbitration, next-state and memory strobes; outputs held low while reset is asserted.
  always_comb begin
    w_state_next     = r_state;
    w_force          = 1'b0;
    w_req_ready      = 1'b0;
    w_bus_accept     = 1'b0;
    w_scrub_issue    = 1'b0;
    w_mem_clk_en     = 1'b0;
    w_mem_write_en   = 1'b0;
    w_mem_addr       = '0;
    w_mem_write_data = '0;
    case (r_state)
      ST_IDLE: begin
        if (rst) begin
          // Forced scrub beats the bus; otherwise the bus beats a pending scrub.
          w_force       = w_pending_eff && (r_defer_cnt == DEFER_MAX);
          w_req_ready   = !w_force;
          w_bus_accept  = bus.req_valid && w_req_ready;
          w_scrub_issue = w_pending_eff && !w_bus_accept;
          if (w_bus_accept) begin
            w_mem_clk_en   = 1'b1;
            w_mem_write_en = bus.req_write;
            w_mem_addr     = bus.req_addr;
            if (bus.req_write) begin
              w_mem_write_data = bus.req_wdata;
            end else begin
              w_state_next = ST_RD_WAIT;
            end
          end else if (w_scrub_issue) begin
            w_mem_clk_en = 1'b1;
            w_mem_addr   = r_scrub_ptr;
            w_state_next = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        // Correctable errors get repaired; everything else returns to idle.
        w_state_next = w_rd_corr ? ST_WRBACK : ST_IDLE;
      end
      ST_WRBACK: begin
        w_mem_clk_en     = 1'b1;
        w_mem_write_en   = 1'b1;
        w_mem_addr       = r_addr;
        w_mem_write_data = r_wb_data;
        w_state_next     = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Remember the source and address of an issued read, and the corrected word to write back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_src_scrub <= 1'b0;
      r_addr      <= '0;
      r_wb_data   <= '0;
    end else begin
      if (w_bus_read) begin
        r_src_scrub <= 1'b0;
        r_addr      <= bus.req_addr;
      end else if (w_scrub_issue) begin
        r_src_scrub <= 1'b1;
        r_addr      <= r_scrub_ptr;
      end
      if (w_rd_corr) begin
        r_wb_data <= i_mem_read_data;
      end
    end
  end

  // One-cycle response pulse: writes answer the cycle after accept, bus reads after the data returns.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      if (w_bus_write) begin
        r_rsp_valid <= 1'b1;
      end else if ((r_state == ST_RD_WAIT) && !r_src_scrub) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= i_mem_read_data;
        r_rsp_error <= i_mem_uncorrectable;
      end
    end
  end

  // Saturating error counters and the address of the latest uncorrectable read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_corr_cnt      <= '0;
      r_uncorr_cnt    <= '0;
      r_last_err_addr <= '0;
    end else begin
      if (w_rd_corr && (r_corr_cnt != CNT_MAX)) begin
        r_corr_cnt <= r_corr_cnt + 1'b1;
      end
      if (w_rd_uncorr) begin
        r_last_err_addr <= r_addr;
        if (r_uncorr_cnt != CNT_MAX) begin
          r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
      end
    end
  end

  // Scrub pointer advances after every scrub read, whatever its outcome, wrapping at the last word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scrub_ptr <= '0;
    end else if ((r_state == ST_RD_WAIT) && r_src_scrub) begin
      r_scrub_ptr <= (r_scrub_ptr == PTR_LAST) ? '0 : r_scrub_ptr + 1'b1;
    end
  end

  // Scrub interval timer; holds while scrubbing is disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_timer_run) begin
      r_timer <= (r_timer == TIMER_LAST) ? '0 : r_timer + 1'b1;
    end
  end

  // Pending flag: set on expiry (merged if already set), cleared on issue or when disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scrub_pending <= 1'b0;
    end else if (!i_scrub_en) begin
      r_scrub_pending <= 1'b0;
    end else if (w_timer_expire) begin
      r_scrub_pending <= 1'b1;
    end else if (w_scrub_issue) begin
      r_scrub_pending <= 1'b0;
    end
  end

  // Defer counter: cycles a pending scrub has waited, saturating at the force threshold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_defer_cnt <= '0;
    end else if (!w_pending_eff || w_scrub_issue) begin
      r_defer_cnt <= '0;
    end else if (r_defer_cnt != DEFER_MAX) begin
      r_defer_cnt <= r_defer_cnt + 1'b1;
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_error    = r_rsp_error;

  assign o_mem_clk_en     = w_mem_clk_en;
  assign o_mem_addr       = w_mem_addr;
  assign o_mem_write_en   = w_mem_write_en;
  assign o_mem_write_data = w_mem_write_data;

  assign o_corr_count     = r_corr_cnt;
  assign o_uncorr_count   = r_uncorr_cnt;
  assign o_last_err_addr  = r_last_err_addr;

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Directed bench for ecc_mem_ctrl using small scrub/defer/counter parameters,
// with a behavioural memory that can inject correctable or uncorrectable errors.
module tb_ecc_mem_ctrl;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          scrub_en;
  logic          mem_clk_en;
  logic [AW-1:0] mem_addr;
  logic          mem_write_en;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          mem_error;
  logic          mem_unc;
  logic [CW-1:0] corr_count;
  logic [CW-1:0] uncorr_count;
  logic [AW-1:0] last_err_addr;

  // Error injection controls for the memory model.
  logic          inj_err;
  logic          inj_unc;
  logic [DW-1:0] inj_data;

  int errors;
  int checks;

  ecc_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  ecc_mem_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4),
    .SCRUB_INTERVAL(4), .MAX_DEFER(3), .CNT_WIDTH(CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_scrub_en         (scrub_en),
    .bus                (bus_if.slave),
    .o_mem_clk_en       (mem_clk_en),
    .o_mem_addr         (mem_addr),
    .o_mem_write_en     (mem_write_en),
    .o_mem_write_data   (mem_write_data),
    .i_mem_read_data    (mem_read_data),
    .i_mem_error        (mem_error),
    .i_mem_uncorrectable(mem_unc),
    .o_corr_count       (corr_count),
    .o_uncorr_count     (uncorr_count),
    .o_last_err_addr    (last_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency; injected errors replace the returned word.
  logic [DW-1:0] tb_mem [0:15];
  always @(posedge clk) begin
    mem_error <= 1'b0;
    mem_unc   <= 1'b0;
    if (mem_clk_en) begin
      if (mem_write_en) begin
        tb_mem[mem_addr[3:0]] <= mem_write_data;
      end else begin
        mem_read_data <= inj_err ? inj_data : tb_mem[mem_addr[3:0]];
        mem_error     <= inj_err;
        mem_unc       <= inj_unc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
  endtask

  task automatic bus_req(input logic wr, input int addr, input logic [DW-1:0] data);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = wr;
    bus_if.req_addr  = AW'(addr);
    bus_if.req_wdata = data;
  endtask

  task automatic clear_inj();
    inj_err  = 1'b0;
    inj_unc  = 1'b0;
    inj_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    scrub_en = 1'b0;
    bus_req(1'b1, 3, 32'h55);
    repeat (3) tick();
    #1;
    checks++; if (bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus_if.rsp_valid); end
    checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", bus_if.req_ready); end
    checks++; if (mem_clk_en !== 1'b0) begin errors++; $display("FAIL reset_mem_clk_en got=%b exp=0", mem_clk_en); end
    checks++; if (corr_count !== 2'd0 || uncorr_count !== 2'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", corr_count, uncorr_count); end
    checks++; if (last_err_addr !== 13'd0) begin errors++; $display("FAIL reset_last_err got=%0d exp=0", last_err_addr); end
    bus_idle();
    rst = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_write_read();
    bus_req(1'b1, 5, 32'hCAFE);
    #1;
    checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got=%b exp=1", bus_if.req_ready); end
    checks++; if (mem_clk_en !== 1'b1 || mem_write_en !== 1'b1 || mem_addr !== 13'd5 || mem_write_data !== 32'hCAFE)
      begin errors++; $display("FAIL wr_strobe got=en%b we%b a%0d d%h exp=en1 we1 a5 dcafe", mem_clk_en, mem_write_en, mem_addr, mem_write_data); end
    tick();
    bus_req(1'b0, 5, 32'h0);
    #1;
    checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'h0 || bus_if.rsp_error !== 1'b0)
      begin errors++; $display("FAIL wr_rsp got=v%b d%h e%b exp=v1 d0 e0", bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_error); end
    checks++; if (mem_clk_en !== 1'b1 || mem_write_en !== 1'b0 || mem_addr !== 13'd5)
      begin errors++; $display("FAIL rd_strobe got=en%b we%b a%0d exp=en1 we0 a5", mem_clk_en, mem_write_en, mem_addr); end
    $display("write: addr=5 data=cafe");
    tick();
    bus_idle();
    #1;
    checks++; if (bus_if.rsp_valid !== 1'b0 || bus_if.req_ready !== 1'b0 || mem_clk_en !== 1'b0)
      begin errors++; $display("FAIL rd_wait got=v%b r%b en%b exp=v0 r0 en0", bus_if.rsp_valid, bus_if.req_ready, mem_clk_en); end
    tick();
    #1;
    checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'hCAFE || bus_if.rsp_error !== 1'b0)
      begin errors++; $display("FAIL rd_rsp got=v%b d%h e%b exp=v1 dcafe e0", bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_error); end
    $display("read: addr=5 data=%h", bus_if.rsp_rdata);
    tick();
  endtask

  task automatic test_correctable();
    inj_err = 1'b1; inj_unc = 1'b0; inj_data = 32'h1234;
    bus_req(1'b0, 7, 32'h0);
    #1;
    checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL corr_ready got=%b exp=1", bus_if.req_ready); end
    tick();
    bus_idle();
    clear_inj();
    tick();
    #1;
    checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'h1234 || bus_if.rsp_error !== 1'b0)
      begin errors++; $display("FAIL corr_rsp got=v%b d%h e%b exp=v1 d1234 e0", bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_error); end
    checks++; if (mem_clk_en !== 1'b1 || mem_write_en !== 1'b1 || mem_addr !== 13'd7 || mem_write_data !== 32'h1234)
      begin errors++; $display("FAIL corr_wrback got=en%b we%b a%0d d%h exp=en1 we1 a7 d1234", mem_clk_en, mem_write_en, mem_addr, mem_write_data); end
    checks++; if (corr_count !== 2'd1) begin errors++; $display("FAIL corr_count got=%0d exp=1", corr_count); end
    checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL corr_wrback_ready got=%b exp=0", bus_if.req_ready); end
    $display("read: addr=7 corrected data=%h", bus_if.rsp_rdata);
    tick();
    #1;
    checks++; if (mem_clk_en !== 1'b0 || bus_if.req_ready !== 1'b1)
      begin errors++; $display("FAIL corr_idle got=en%b r%b exp=en0 r1", mem_clk_en, bus_if.req_ready); end
  endtask

  task automatic test_uncorrectable();
    tick();
    inj_err = 1'b1; inj_unc = 1'b1; inj_data = 32'hDEAD;
    bus_req(1'b0, 9, 32'h0);
    tick();
    bus_idle();
    clear_inj();
    tick();
    #1;
    checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_error !== 1'b1)
      begin errors++; $display("FAIL unc_rsp got=v%b e%b exp=v1 e1", bus_if.rsp_valid, bus_if.rsp_error); end
    checks++; if (mem_clk_en !== 1'b0) begin errors++; $display("FAIL unc_no_write got=%b exp=0", mem_clk_en); end
    checks++; if (uncorr_count !== 2'd1 || corr_count !== 2'd1)
      begin errors++; $display("FAIL unc_counts got=%0d/%0d exp=1/1", corr_count, uncorr_count); end
    checks++; if (last_err_addr !== 13'd9) begin errors++; $display("FAIL unc_last_err got=%0d exp=9", last_err_addr); end
    checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL unc_idle_ready got=%b exp=1", bus_if.req_ready); end
    $display("read: addr=9 uncorrectable");
    tick();
  endtask

  task automatic test_scrub();
    int idx;
    idx = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    scrub_en = 1'b1;
    for (int k = 0; k < 22; k++) begin
      #1;
      if (mem_clk_en === 1'b1) begin
        checks++;
        if (mem_write_en !== 1'b0 || mem_addr !== AW'(idx % 4) || k != 4 * (idx + 1))
          begin errors++; $display("FAIL scrub_read got=cyc%0d a%0d we%b exp=cyc%0d a%0d we0", k, mem_addr, mem_write_en, 4 * (idx + 1), idx % 4); end
        $display("scrub: cycle=%0d addr=%0d", k, mem_addr);
        idx++;
      end
      tick();
    end
    checks++; if (idx != 5) begin errors++; $display("FAIL scrub_count got=%0d exp=5", idx); end
    scrub_en = 1'b0;
    tick();
  endtask

  task automatic test_defer();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    scrub_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus_req(1'b1, 12, DW'(k));
      #1;
      if (k <= 6) begin
        checks++;
        if (bus_if.req_ready !== 1'b1 || mem_clk_en !== 1'b1 || mem_write_en !== 1'b1)
          begin errors++; $display("FAIL defer_bus_win cyc=%0d got=r%b en%b we%b exp=r1 en1 we1", k, bus_if.req_ready, mem_clk_en, mem_write_en); end
      end else if (k == 7) begin
        checks++;
        if (bus_if.req_ready !== 1'b0 || mem_clk_en !== 1'b1 || mem_write_en !== 1'b0 || mem_addr !== 13'd0)
          begin errors++; $display("FAIL defer_force got=r%b en%b we%b a%0d exp=r0 en1 we0 a0", bus_if.req_ready, mem_clk_en, mem_write_en, mem_addr); end
        $display("defer: forced scrub at cycle=%0d", k);
      end else begin
        checks++;
        if (bus_if.req_ready !== 1'b0 || mem_clk_en !== 1'b0)
          begin errors++; $display("FAIL defer_rd_wait got=r%b en%b exp=r0 en0", bus_if.req_ready, mem_clk_en); end
      end
      tick();
    end
    bus_idle();
    scrub_en = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    int exp_corr;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      inj_err = 1'b1; inj_unc = 1'b0; inj_data = DW'(32'h100 + i);
      bus_req(1'b0, 2 + i, 32'h0);
      tick();
      bus_idle();
      clear_inj();
      tick();
      #1;
      exp_corr = (i < 3) ? i + 1 : 3;
      checks++;
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== DW'(32'h100 + i) || corr_count !== CW'(exp_corr))
        begin errors++; $display("FAIL sat_corr i=%0d got=v%b d%h c%0d exp=v1 d%h c%0d", i, bus_if.rsp_valid, bus_if.rsp_rdata, corr_count, 32'h100 + i, exp_corr); end
      $display("read: addr=%0d corrected, corr_count=%0d", 2 + i, corr_count);
      tick();
    end
    // Reset while a read is outstanding: its response must never appear.
    bus_req(1'b0, 3, 32'h0);
    tick();
    bus_idle();
    rst = 1'b0;
    tick();
    #1;
    checks++; if (bus_if.rsp_valid !== 1'b0 || bus_if.rsp_rdata !== 32'h0 || bus_if.rsp_error !== 1'b0)
      begin errors++; $display("FAIL midrst_rsp got=v%b d%h e%b exp=v0 d0 e0", bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_error); end
    checks++; if (bus_if.req_ready !== 1'b0 || mem_clk_en !== 1'b0 || mem_write_en !== 1'b0 || mem_addr !== 13'd0)
      begin errors++; $display("FAIL midrst_mem got=r%b en%b we%b a%0d exp=all0", bus_if.req_ready, mem_clk_en, mem_write_en, mem_addr); end
    checks++; if (corr_count !== 2'd0 || uncorr_count !== 2'd0 || last_err_addr !== 13'd0)
      begin errors++; $display("FAIL midrst_counts got=%0d/%0d/%0d exp=0/0/0", corr_count, uncorr_count, last_err_addr); end
    rst = 1'b1;
    tick();
    #1;
    checks++; if (bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0)
      begin errors++; $display("FAIL midrst_recover got=r%b v%b exp=r1 v0", bus_if.req_ready, bus_if.rsp_valid); end
    $display("reset: mid-read abandon done");
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_inj();
    bus_idle();
    rst = 1'b0;
    scrub_en = 1'b0;
    tick();
    test_reset();
    test_write_read();
    test_correctable();
    test_uncorrectable();
    test_scrub();
    test_defer();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
